// File: rtl/decode_stage_ctrl.sv
// decode_stage_ctrl: ID-stage control for a small MIPS-like pipeline.
// Decodes the IF/ID instruction into a registered EX control bundle with a
// valid/ready handshake, squashes on flush and halts the front end on SYSCALL.
// Optional build macro DECODE_LOAD_USE_HAZARD_EN adds a one-cycle load-use
// interlock; without it the hazard term is tied low.
//
// state | meaning
// RUN   | decoding and issuing instructions
// HALT  | SYSCALL issued; only bubbles until resume
module decode_stage_ctrl #(
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        instr,
    input  logic               instr_valid,
    output logic               id_ready,
    input  logic               flush,
    input  logic               ex_ready,
    output logic               ex_valid,
    output logic               ex_reg_write,
    output logic               ex_mem_to_reg,
    output logic               ex_mem_write,
    output logic               ex_alu_src_b,
    output logic               ex_signed_ext,
    output logic               ex_syscall,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [REG_W-1:0]   ex_dst,
    output logic [2:0]         ex_br,
    output logic [1:0]         ex_mem_access,
    output logic               halted,
    input  logic               resume
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t state_q, state_d;

    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd;
    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign funct = instr[5:0];

    // shamt is consumed by the EX stage straight from the instruction word
    logic unused_bits;
    assign unused_bits = ^{instr[10:6], rs};

    logic               d_rw, d_m2r, d_mw, d_srcb, d_sext, d_sys;
    logic [3:0]         d_alu;
    logic [ALUOP_W-1:0] d_alu_w;
    logic [REG_W-1:0]   d_dst;
    logic [2:0]         d_br;
    logic [1:0]         d_ma;
    logic               hazard, transfer;

    // Combinational decode; anything unlisted falls through as an all-zero NOP
    always_comb begin
        d_rw   = 1'b0;
        d_m2r  = 1'b0;
        d_mw   = 1'b0;
        d_srcb = 1'b0;
        d_sext = 1'b0;
        d_sys  = 1'b0;
        d_alu  = 4'd0;
        d_dst  = '0;
        d_br   = 3'd0;
        d_ma   = 2'b00;
        case (op)
            6'd0: begin
                case (funct)
                    6'd0:  begin d_rw = 1'b1; d_alu = 4'd0;  d_dst = REG_W'(rd); end
                    6'd2:  begin d_rw = 1'b1; d_alu = 4'd2;  d_dst = REG_W'(rd); end
                    6'd3:  begin d_rw = 1'b1; d_alu = 4'd1;  d_dst = REG_W'(rd); end
                    6'd8:  begin d_br = 3'd6;                d_dst = REG_W'(rd); end
                    6'd12: begin d_sys = 1'b1;               d_dst = REG_W'(rd); end
                    6'd32, 6'd33:
                           begin d_rw = 1'b1; d_alu = 4'd5;  d_dst = REG_W'(rd); end
                    6'd34, 6'd35:
                           begin d_rw = 1'b1; d_alu = 4'd6;  d_dst = REG_W'(rd); end
                    6'd36: begin d_rw = 1'b1; d_alu = 4'd7;  d_dst = REG_W'(rd); end
                    6'd37: begin d_rw = 1'b1; d_alu = 4'd8;  d_dst = REG_W'(rd); end
                    6'd39: begin d_rw = 1'b1; d_alu = 4'd10; d_dst = REG_W'(rd); end
                    6'd42: begin d_rw = 1'b1; d_alu = 4'd11; d_dst = REG_W'(rd); end
                    6'd43: begin d_rw = 1'b1; d_alu = 4'd12; d_dst = REG_W'(rd); end
                    default: ;
                endcase
            end
            6'd1:  begin d_br = 3'd3; d_alu = 4'd11; d_sext = 1'b1; d_dst = REG_W'(rt); end
            6'd2:  begin d_br = 3'd4; d_dst = REG_W'(rt); end
            6'd3:  begin d_br = 3'd5; d_rw = 1'b1; d_dst = REG_W'(31); end
            6'd4:  begin d_br = 3'd1; d_sext = 1'b1; d_dst = REG_W'(rt); end
            6'd5:  begin d_br = 3'd2; d_sext = 1'b1; d_dst = REG_W'(rt); end
            6'd8:  begin d_rw = 1'b1; d_srcb = 1'b1; d_sext = 1'b1; d_alu = 4'd5;  d_dst = REG_W'(rt); end
            6'd9:  begin d_rw = 1'b1; d_srcb = 1'b1; d_alu = 4'd5;  d_dst = REG_W'(rt); end
            6'd10: begin d_rw = 1'b1; d_srcb = 1'b1; d_sext = 1'b1; d_alu = 4'd11; d_dst = REG_W'(rt); end
            6'd12: begin d_rw = 1'b1; d_srcb = 1'b1; d_alu = 4'd7;  d_dst = REG_W'(rt); end
            6'd13: begin d_rw = 1'b1; d_srcb = 1'b1; d_alu = 4'd8;  d_dst = REG_W'(rt); end
            6'd14: begin d_rw = 1'b1; d_srcb = 1'b1; d_alu = 4'd9;  d_dst = REG_W'(rt); end
            6'd33: begin d_rw = 1'b1; d_srcb = 1'b1; d_sext = 1'b1; d_m2r = 1'b1; d_alu = 4'd5;
                         d_ma = 2'b01; d_dst = REG_W'(rt); end
            6'd35: begin d_rw = 1'b1; d_srcb = 1'b1; d_sext = 1'b1; d_m2r = 1'b1; d_alu = 4'd5;
                         d_dst = REG_W'(rt); end
            6'd43: begin d_mw = 1'b1; d_srcb = 1'b1; d_sext = 1'b1; d_alu = 4'd5; d_dst = REG_W'(rt); end
            default: ;
        endcase
        d_alu_w      = '0;
        d_alu_w[3:0] = d_alu;
    end

`ifdef DECODE_LOAD_USE_HAZARD_EN
    logic uses_rt;
    assign uses_rt = (op == 6'd0) | (op == 6'd4) | (op == 6'd5) | (op == 6'd43);
    assign hazard  = ex_valid & ex_mem_to_reg & (ex_dst != '0) &
                     ((ex_dst == REG_W'(rs)) | ((ex_dst == REG_W'(rt)) & uses_rt));
`else
    assign hazard = 1'b0;
`endif

    assign id_ready = ex_ready & (state_q == RUN) & ~hazard & ~flush;
    assign transfer = instr_valid & id_ready;
    assign halted   = (state_q == HALT);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // FSM next state; flush already blocks the transfer so it cannot halt
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (transfer && d_sys) state_d = HALT;
            HALT:    if (resume)            state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // EX bundle register: squash, load, bubble or hold under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_alu_src_b  <= 1'b0;
            ex_signed_ext <= 1'b0;
            ex_syscall    <= 1'b0;
            ex_alu_op     <= '0;
            ex_dst        <= '0;
            ex_br         <= 3'd0;
            ex_mem_access <= 2'b00;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (transfer) begin
            ex_valid      <= 1'b1;
            ex_reg_write  <= d_rw;
            ex_mem_to_reg <= d_m2r;
            ex_mem_write  <= d_mw;
            ex_alu_src_b  <= d_srcb;
            ex_signed_ext <= d_sext;
            ex_syscall    <= d_sys;
            ex_alu_op     <= d_alu_w;
            ex_dst        <= d_dst;
            ex_br         <= d_br;
            ex_mem_access <= d_ma;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Self-checking bench for decode_stage_ctrl: directed scenarios then random
// traffic against a mnemonic-level reference model.
module tb_decode_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0, flush = 1'b0, ex_ready = 1'b0, resume = 1'b0;
    logic        id_ready, ex_valid, halted;
    logic        ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_src_b, ex_signed_ext, ex_syscall;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_dst;
    logic [2:0]  ex_br;
    logic [1:0]  ex_mem_access;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_stage_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
        .ex_alu_src_b(ex_alu_src_b), .ex_signed_ext(ex_signed_ext), .ex_syscall(ex_syscall),
        .ex_alu_op(ex_alu_op), .ex_dst(ex_dst), .ex_br(ex_br), .ex_mem_access(ex_mem_access),
        .halted(halted), .resume(resume)
    );

    typedef enum {M_NOP, M_SLL, M_SRL, M_SRA, M_JR, M_SYSCALL, M_ADD, M_ADDU, M_SUB, M_SUBU,
                  M_AND, M_OR, M_NOR, M_SLT, M_SLTU, M_BGEZ, M_J, M_JAL, M_BEQ, M_BNE,
                  M_ADDI, M_ADDIU, M_SLTI, M_ANDI, M_ORI, M_XORI, M_LH, M_LW, M_SW} mn_t;

    typedef struct packed {
        logic       rw, m2r, mw, srcb, sext, sys;
        logic [3:0] alu;
        logic [4:0] dst;
        logic [2:0] br;
        logic [1:0] ma;
    } bund_t;

    bund_t obs;
    assign obs = {ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_src_b, ex_signed_ext,
                  ex_syscall, ex_alu_op, ex_dst, ex_br, ex_mem_access};

    bund_t m_b;
    logic  m_valid, m_run, last_idr;

    function automatic mn_t mnem(input logic [31:0] i);
        mn_t m = M_NOP;
        if (i[31:26] == 6'd0) begin
            case (int'(i[5:0]))
                0: m = M_SLL;   2: m = M_SRL;   3: m = M_SRA;   8: m = M_JR;
                12: m = M_SYSCALL; 32: m = M_ADD; 33: m = M_ADDU; 34: m = M_SUB;
                35: m = M_SUBU; 36: m = M_AND;  37: m = M_OR;   39: m = M_NOR;
                42: m = M_SLT;  43: m = M_SLTU; default: m = M_NOP;
            endcase
        end else begin
            case (int'(i[31:26]))
                1: m = M_BGEZ;  2: m = M_J;     3: m = M_JAL;   4: m = M_BEQ;
                5: m = M_BNE;   8: m = M_ADDI;  9: m = M_ADDIU; 10: m = M_SLTI;
                12: m = M_ANDI; 13: m = M_ORI;  14: m = M_XORI; 33: m = M_LH;
                35: m = M_LW;   43: m = M_SW;   default: m = M_NOP;
            endcase
        end
        return m;
    endfunction

    function automatic bund_t model(input logic [31:0] i);
        bund_t b = '0;
        mn_t   m = mnem(i);
        b.rw   = m inside {M_SLL, M_SRL, M_SRA, M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR,
                           M_NOR, M_SLT, M_SLTU, M_JAL, M_ADDI, M_ADDIU, M_ANDI, M_ORI,
                           M_SLTI, M_XORI, M_LW, M_LH};
        b.srcb = m inside {M_ADDI, M_ADDIU, M_ANDI, M_ORI, M_SLTI, M_XORI, M_LW, M_LH, M_SW};
        b.sext = m inside {M_BEQ, M_BNE, M_BGEZ, M_ADDI, M_SLTI, M_LW, M_LH, M_SW};
        b.m2r  = m inside {M_LW, M_LH};
        b.mw   = (m == M_SW);
        b.sys  = (m == M_SYSCALL);
        b.ma   = (m == M_LH) ? 2'b01 : 2'b00;
        if (m inside {M_SRA}) b.alu = 1;
        else if (m inside {M_SRL}) b.alu = 2;
        else if (m inside {M_ADD, M_ADDU, M_ADDI, M_ADDIU, M_LW, M_SW, M_LH}) b.alu = 5;
        else if (m inside {M_SUB, M_SUBU}) b.alu = 6;
        else if (m inside {M_AND, M_ANDI}) b.alu = 7;
        else if (m inside {M_OR, M_ORI}) b.alu = 8;
        else if (m inside {M_XORI}) b.alu = 9;
        else if (m inside {M_NOR}) b.alu = 10;
        else if (m inside {M_SLT, M_SLTI, M_BGEZ}) b.alu = 11;
        else if (m inside {M_SLTU}) b.alu = 12;
        else b.alu = 0;
        if (m == M_BEQ) b.br = 1;
        else if (m == M_BNE) b.br = 2;
        else if (m == M_BGEZ) b.br = 3;
        else if (m == M_J) b.br = 4;
        else if (m == M_JAL) b.br = 5;
        else if (m == M_JR) b.br = 6;
        if (m == M_NOP) b.dst = 0;
        else if (i[31:26] == 6'd0) b.dst = i[15:11];
        else if (m == M_JAL) b.dst = 5'd31;
        else b.dst = i[20:16];
        return b;
    endfunction

    function automatic logic model_hazard(input logic [31:0] i);
`ifdef DECODE_LOAD_USE_HAZARD_EN
        mn_t  m = mnem(i);
        logic reads_rt = (i[31:26] == 6'd0) || (m inside {M_BEQ, M_BNE, M_SW});
        return m_valid && m_b.m2r && (m_b.dst != 0) &&
               ((m_b.dst == i[25:21]) || ((m_b.dst == i[20:16]) && reads_rt));
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_run   = 1'b1;
        m_b     = '0;
    endtask

    // One clock cycle: drive after negedge, check id_ready, check EX outputs after posedge
    task automatic step(input logic [31:0] i, input logic v, input logic r,
                        input logic f, input logic rs);
        bund_t d;
        logic  exp_idr, xfer;
        instr = i; instr_valid = v; ex_ready = r; flush = f; resume = rs;
        #1;
        exp_idr  = r & m_run & ~model_hazard(i) & ~f;
        last_idr = id_ready;
        chk("id_ready", {31'd0, id_ready}, {31'd0, exp_idr});
        xfer = v & exp_idr;
        d    = model(i);
        @(posedge clk);
        if (f) m_valid = 1'b0;
        else if (xfer) begin m_valid = 1'b1; m_b = d; end
        else if (r) m_valid = 1'b0;
        if (m_run && xfer && d.sys) m_run = 1'b0;
        else if (!m_run && rs) m_run = 1'b1;
        #1;
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
        chk("halted", {31'd0, halted}, {31'd0, ~m_run});
        if (m_valid) chk("bundle", 32'(obs), 32'(m_b));
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [11:0] pool [28] = '{
            {6'd0, 6'd0}, {6'd0, 6'd2}, {6'd0, 6'd3}, {6'd0, 6'd8}, {6'd0, 6'd12},
            {6'd0, 6'd32}, {6'd0, 6'd33}, {6'd0, 6'd34}, {6'd0, 6'd35}, {6'd0, 6'd36},
            {6'd0, 6'd37}, {6'd0, 6'd39}, {6'd0, 6'd42}, {6'd0, 6'd43},
            {6'd1, 6'd0}, {6'd2, 6'd0}, {6'd3, 6'd0}, {6'd4, 6'd0}, {6'd5, 6'd0},
            {6'd8, 6'd0}, {6'd9, 6'd0}, {6'd10, 6'd0}, {6'd12, 6'd0}, {6'd13, 6'd0},
            {6'd14, 6'd0}, {6'd33, 6'd0}, {6'd35, 6'd0}, {6'd43, 6'd0}};
        int          k = int'($urandom_range(0, 30));
        logic [31:0] w = $urandom;
        if (k >= 28) return w;
        w[31:26] = pool[k][11:6];
        w[25:21] = 5'($urandom_range(0, 3));
        w[20:16] = 5'($urandom_range(0, 3));
        w[15:11] = 5'($urandom_range(0, 3));
        if (pool[k][11:6] == 6'd0) w[5:0] = pool[k][5:0];
        return w;
    endfunction

    localparam logic [31:0] ADDU_3_1_2 = 32'h0022_1821;
    localparam logic [31:0] LW_4_0_1   = 32'h8C24_0000;
    localparam logic [31:0] ADD_5_4_2  = 32'h0082_2820;
    localparam logic [31:0] SYSCALL    = 32'h0000_000C;
    localparam logic [31:0] ORI_7      = 32'h3427_1234;

    initial begin
        bund_t saved;
        logic  hz_on;
`ifdef DECODE_LOAD_USE_HAZARD_EN
        hz_on = 1'b1;
`else
        hz_on = 1'b0;
`endif
        model_reset();
        #1;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_bundle", 32'(obs), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ADDU $3,$1,$2
        step(ADDU_3_1_2, 1, 1, 0, 0);
        chk("addu_valid", {31'd0, ex_valid}, 32'd1);
        chk("addu_alu", 32'(ex_alu_op), 32'd5);
        chk("addu_dst", 32'(ex_dst), 32'd3);
        chk("addu_rw", {31'd0, ex_reg_write}, 32'd1);
        chk("addu_srcb", {31'd0, ex_alu_src_b}, 32'd0);

        // backpressure for three cycles
        saved = obs;
        for (int n = 0; n < 3; n++) begin
            step(ORI_7, 1, 0, 0, 0);
            chk("stall_hold", 32'(obs), 32'(saved));
            chk("stall_idr", {31'd0, last_idr}, 32'd0);
            chk("stall_valid", {31'd0, ex_valid}, 32'd1);
        end
        step(ORI_7, 0, 1, 0, 0);
        chk("bubble_valid", {31'd0, ex_valid}, 32'd0);

        // load-use pair
        step(LW_4_0_1, 1, 1, 0, 0);
        step(ADD_5_4_2, 1, 1, 0, 0);
        chk("lu_idr", {31'd0, last_idr}, {31'd0, ~hz_on});
        chk("lu_valid", {31'd0, ex_valid}, {31'd0, ~hz_on});
        if (hz_on) step(ADD_5_4_2, 1, 1, 0, 0);
        chk("lu_add_dst", 32'(ex_dst), 32'd5);
        step(ADD_5_4_2, 0, 1, 0, 0);

        // SYSCALL squashed by flush
        step(SYSCALL, 1, 1, 1, 0);
        chk("sysflush_halted", {31'd0, halted}, 32'd0);
        chk("sysflush_valid", {31'd0, ex_valid}, 32'd0);

        // SYSCALL halt, flush in halt, resume
        step(SYSCALL, 1, 1, 0, 0);
        chk("sys_flag", {31'd0, ex_syscall}, 32'd1);
        chk("sys_halted", {31'd0, halted}, 32'd1);
        step(ADDU_3_1_2, 1, 1, 0, 0);
        chk("halt_idr", {31'd0, last_idr}, 32'd0);
        chk("halt_bubble", {31'd0, ex_valid}, 32'd0);
        step(ADDU_3_1_2, 1, 1, 1, 0);
        chk("halt_flush", {31'd0, halted}, 32'd1);
        step(ADDU_3_1_2, 1, 1, 0, 1);
        chk("resume_halted", {31'd0, halted}, 32'd0);
        step(ADDU_3_1_2, 1, 1, 0, 1);
        chk("resume_decode", {31'd0, ex_valid}, 32'd1);

        // reset between edges while halted
        step(SYSCALL, 1, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, ex_valid}, 32'd0);
        chk("midrst_halted", {31'd0, halted}, 32'd0);
        chk("midrst_bundle", 32'(obs), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(ADDU_3_1_2, 1, 1, 0, 0);
        chk("postrst_valid", {31'd0, ex_valid}, 32'd1);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            step(rand_instr(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decode_stage_ctrl.md
DECODE_STAGE_CTRL -- requirements
Module: decode_stage_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-index width.
REQ-002 SHALL have parameter ALUOP_W, default 4 (min 4), alu_op width; upper bits beyond 4 are zero.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  instruction from the IF/ID register.
- instr_valid  in  1  instr is valid.
- id_ready  out  1  instr is consumed this cycle.
- flush  in  1  branch/jump resolved taken; squash.
- ex_ready  in  1  EX stage accepts the ex_* bundle.
- ex_valid  out  1  ex_* bundle valid.
- ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_src_b, ex_signed_ext, ex_syscall  out  1 each  registered controls.
- ex_alu_op  out  ALUOP_W  ALU operation.
- ex_dst  out  REG_W  destination register: rd for R-type, 31 for JAL, rt otherwise.
- ex_br  out  3  0 none, 1 BEQ, 2 BNE, 3 BGEZ, 4 J, 5 JAL, 6 JR.
- ex_mem_access  out  2  00 word, 01 halfword (LH).
- halted  out  1  core halted by SYSCALL.
- resume  in  1  leave halt.

Function
REQ-004 SHALL decode op=instr[31:26], funct=instr[5:0] for: R-type (op 0) SLL 0, SRL 2, SRA 3, JR 8, SYSCALL 12, ADD 32, ADDU 33, SUB 34, SUBU 35, AND 36, OR 37, NOR 39, SLT 42, SLTU 43; BGEZ 1, J 2, JAL 3, BEQ 4, BNE 5, ADDI 8, ADDIU 9, SLTI 10, ANDI 12, ORI 13, XORI 14, LH 33, LW 35, SW 43.
REQ-005 SHALL produce alu_op: SLL/BEQ/BNE/J/JAL/JR 0, SRA 1, SRL 2, ADD/ADDU/ADDI/ADDIU/LW/SW/LH 5, SUB/SUBU 6, AND/ANDI 7, OR/ORI 8, XORI 9, NOR 10, SLT/SLTI/BGEZ 11, SLTU 12.
REQ-006 SHALL set reg_write for all ALU R-types, JAL, ADDI, ADDIU, ANDI, ORI, SLTI, XORI, LW, LH; alu_src_b for ADDI, ADDIU, ANDI, ORI, SLTI, XORI, LW, LH, SW; signed_ext for BEQ, BNE, BGEZ, ADDI, SLTI, LW, LH, SW; mem_to_reg for LW, LH; mem_write for SW.
REQ-007 SHALL treat unlisted encodings as NOP: all controls 0, ex_br 0, still valid.
REQ-008 SHALL register the decoded bundle into ex_* on a transfer (instr_valid & id_ready); latency one cycle.
REQ-009 SHALL hold ex_* and ex_valid stable while ex_valid & !ex_ready.
REQ-010 SHALL clear ex_valid on an edge where ex_ready=1 and no transfer occurs (bubble).
REQ-011 SHALL drive id_ready = ex_ready & (state==RUN) & !hazard & !flush.
REQ-012 SHALL, on flush=1, clear ex_valid at the next edge regardless of ex_ready and discard the current instr.
REQ-013 SHALL implement FSM RUN/HALT: RUN->HALT on a SYSCALL transfer; HALT->RUN on resume=1; halted=1 exactly in HALT.
REQ-014 SHALL, in HALT, deliver the pending SYSCALL bundle (ex_syscall=1) then issue bubbles; flush in HALT has no state effect.
REQ-015 SHALL give flush priority over a same-cycle SYSCALL: no transfer, FSM stays RUN.
REQ-016 SHALL ignore resume in RUN.

Reset
REQ-017 SHALL, on rst_n=0, immediately clear ex_valid, all ex_* outputs to 0, halted to 0, FSM to RUN, irrespective of clk.
REQ-018 SHALL resume decoding on the first rising edge after rst_n deasserts; reset mid-HALT returns to RUN.

Configuration
REQ-019 SHALL support macro DECODE_LOAD_USE_HAZARD_EN: when defined, hazard=1 when ex_valid & ex_mem_to_reg & ex_dst!=0 & (ex_dst==rs | (ex_dst==rt & instr uses rt: R-type, BEQ, BNE, SW)), stalling one cycle and inserting a bubble; when undefined, hazard is tied 0 and no interlock exists.

Verification
REQ-020 ADDU $3,$1,$2 (0x00221821), valid, ex_ready=1 -> next cycle ex_valid=1, ex_alu_op=5, ex_dst=3, ex_reg_write=1, ex_alu_src_b=0.
REQ-021 LW $4,0($1) then ADD $5,$4,$2 with macro on -> id_ready=0 one cycle, one bubble, ADD issues one cycle later; macro off -> no stall.
REQ-022 ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* unchanged, id_ready=0.
REQ-023 SYSCALL (0x0000000C) -> ex_syscall=1 next cycle, halted=1, id_ready=0; resume=1 -> halted=0 next cycle, decoding resumes.
REQ-024 SYSCALL with flush=1 same cycle -> no transfer, halted stays 0, ex_valid=0 next cycle.
REQ-025 rst_n pulled low mid-HALT between clock edges -> ex_valid=0, halted=0 immediately.
